// File: rtl/mem_arb_pkg.sv
// Shared core defines: read-owner encoding and default fetch-starvation limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam int MAX_STREAK_DEF = 4;

endpackage

// File: rtl/mem_arb_dff_rst_en_clr.sv
// Generic register with synchronous reset, synchronous clear and load enable.
// Latency: 1 cycle from d to q.
// Backpressure: none; en simply holds the current value.
module dff_rst_en_clr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and load/store onto one single-port synchronous memory, ls first with a fetch anti-starvation limit.
// Latency: grant is combinational; read data returns exactly one cycle after the grant.
// Backpressure: the losing requester sees no gnt (fetch also sees o_stall_f) and must hold its request.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic                clk_sys,
    input  logic                rst_sys,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_stall_f,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [DATA_W/8-1:0] i_ls_wstrb,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_en,
    output logic [DATA_W/8-1:0] o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic [SW-1:0] streak_q;
    logic [1:0]    owner_q;
    owner_e        owner_nxt;
    logic          ls_hold;
    logic          ls_gnt;
    logic          if_gnt;
    logic          streak_inc;
    logic          streak_clr;

    // Once ls has won MAX_STREAK times in a row against a waiting fetch, the fetch goes next.
    assign ls_hold = (streak_q == STREAK_MAX) && i_if_req && i_ls_req;
    assign ls_gnt  = !rst_sys && i_ls_req && !ls_hold;
    assign if_gnt  = !rst_sys && i_if_req && !ls_gnt;

    assign o_ls_gnt  = ls_gnt;
    assign o_if_gnt  = if_gnt;
    assign o_stall_f = i_if_req && !if_gnt;

    assign streak_clr = !i_if_req || if_gnt;
    assign streak_inc = ls_gnt && i_if_req && (streak_q != STREAK_MAX);

    // A flush with no older fetch outstanding cancels the fetch granted this cycle;
    // otherwise it only cancels the older response and the new fetch proceeds.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (ls_gnt && !i_ls_we) begin
            owner_nxt = OWN_LS;
        end else if (if_gnt && !(i_if_flush && owner_q != OWN_IF)) begin
            owner_nxt = OWN_IF;
        end
    end

    always_comb begin
        o_mem_en    = ls_gnt || if_gnt;
        o_mem_we    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (ls_gnt) begin
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_wdata;
            if (i_ls_we) begin
                o_mem_we = i_ls_wstrb;
            end
        end else if (if_gnt) begin
            o_mem_addr = i_if_addr;
        end
    end

    // Reset in the response cycle drops the pending read.
    assign o_if_rvalid = !rst_sys && (owner_q == OWN_IF) && !i_if_flush;
    assign o_ls_rvalid = !rst_sys && (owner_q == OWN_LS);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;

    dff_rst_en_clr #(.W(2), .RST_VAL(OWN_NONE)) u_owner (
        .clk (clk_sys),
        .rst (rst_sys),
        .en  (1'b1),
        .clr (1'b0),
        .d   (owner_nxt),
        .q   (owner_q)
    );

    dff_rst_en_clr #(.W(SW), .RST_VAL('0)) u_streak (
        .clk (clk_sys),
        .rst (rst_sys),
        .en  (streak_inc),
        .clr (streak_clr),
        .d   (streak_q + SW'(1)),
        .q   (streak_q)
    );

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: per-cycle model check plus directed literal expectations.
// Latency: model expects read data one cycle after each read grant.
// Backpressure: stimulus holds requests until granted where a grant count matters.
module tb_mem_arb;

    localparam int MAXS = 4;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        i_if_req, i_if_flush, i_ls_req, i_ls_we;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
    logic [3:0]  i_ls_wstrb;
    logic        o_if_gnt, o_if_rvalid, o_stall_f, o_ls_gnt, o_ls_rvalid, o_mem_en;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_we;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS)) dut (
        .clk_sys     (clk_sys),
        .rst_sys     (rst_sys),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .i_if_flush  (i_if_flush),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .o_stall_f   (o_stall_f),
        .i_ls_req    (i_ls_req),
        .i_ls_we     (i_ls_we),
        .i_ls_wstrb  (i_ls_wstrb),
        .i_ls_addr   (i_ls_addr),
        .i_ls_wdata  (i_ls_wdata),
        .o_ls_gnt    (o_ls_gnt),
        .o_ls_rvalid (o_ls_rvalid),
        .o_ls_rdata  (o_ls_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    function automatic logic [31:0] init_word(int w);
        logic [31:0] t;
        t = 32'(w) * 32'h0101_0101;
        return t ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Memory environment: single-port, data valid only in the cycle after a read.
    logic [31:0] env_mem [int];
    int          env_w;
    logic [31:0] env_cur;
    always @(posedge clk_sys) begin
        i_mem_rdata <= 32'hA5A5_A5A5;
        if (o_mem_en) begin
            env_w   = int'(o_mem_addr[31:2]);
            env_cur = env_mem.exists(env_w) ? env_mem[env_w] : init_word(env_w);
            if (o_mem_we != 4'b0) env_mem[env_w] = merge(env_cur, o_mem_wdata, o_mem_we);
            else                  i_mem_rdata <= env_cur;
        end
    end

    // Reference model: who wins this cycle and what data is owed next cycle.
    logic [31:0] ref_mem [int];
    int          m_streak = 0;
    int          m_pend   = 0;   // 0 nothing owed, 1 fetch owed, 2 load owed
    logic [31:0] m_data   = '0;
    bit          chk_on   = 1'b1;

    always @(negedge clk_sys) begin
        bit          e_ls, e_if, e_ifrv, e_lsrv;
        int          w;
        logic [31:0] cur;
        if (chk_on) begin
            e_ifrv = (m_pend == 1) && !rst_sys && !i_if_flush;
            e_lsrv = (m_pend == 2) && !rst_sys;
            e_ls = 0;
            e_if = 0;
            if (!rst_sys) begin
                e_ls = i_ls_req && !(i_if_req && m_streak >= MAXS);
                e_if = i_if_req && !e_ls;
            end
            chk("if_gnt", 32'(o_if_gnt), 32'(e_if));
            chk("ls_gnt", 32'(o_ls_gnt), 32'(e_ls));
            chk("stall_f", 32'(o_stall_f), 32'(i_if_req && !e_if));
            chk("mem_en", 32'(o_mem_en), 32'(e_if || e_ls));
            chk("mem_we", 32'(o_mem_we), (e_ls && i_ls_we) ? 32'(i_ls_wstrb) : 32'd0);
            if (e_ls) chk("mem_addr_ls", o_mem_addr, i_ls_addr);
            if (e_if) chk("mem_addr_if", o_mem_addr, i_if_addr);
            if (e_ls && i_ls_we) chk("mem_wdata", o_mem_wdata, i_ls_wdata);
            chk("if_rvalid", 32'(o_if_rvalid), 32'(e_ifrv));
            chk("ls_rvalid", 32'(o_ls_rvalid), 32'(e_lsrv));
            chk("if_rdata", o_if_rdata, e_ifrv ? m_data : 32'd0);
            chk("ls_rdata", o_ls_rdata, e_lsrv ? m_data : 32'd0);

            if (rst_sys) begin
                m_streak = 0;
                m_pend   = 0;
            end else begin
                if (!i_if_req || e_if)                 m_streak = 0;
                else if (e_ls && m_streak < MAXS)      m_streak++;
                w = e_ls ? int'(i_ls_addr[31:2]) : int'(i_if_addr[31:2]);
                cur = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
                if (e_ls && i_ls_we) begin
                    ref_mem[w] = merge(cur, i_ls_wdata, i_ls_wstrb);
                    m_pend = 0;
                end else if (e_ls) begin
                    m_pend = 2;
                    m_data = cur;
                end else if (e_if && !(i_if_flush && m_pend != 1)) begin
                    m_pend = 1;
                    m_data = cur;
                end else begin
                    m_pend = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    logic [6:0] pat_ls, pat_if;
    int         ls_cnt;

    initial begin
        rst_sys = 1; i_if_req = 1; i_if_addr = 0; i_if_flush = 0;
        i_ls_req = 0; i_ls_we = 0; i_ls_wstrb = 0; i_ls_addr = 0; i_ls_wdata = 0;

        // Reset: fetch request stalls, nothing granted.
        @(negedge clk_sys);
        chk("rst_stall", 32'(o_stall_f), 32'd1);
        chk("rst_mem_en", 32'(o_mem_en), 32'd0);
        tick();
        tick();
        rst_sys = 0; i_if_req = 0;
        @(negedge clk_sys);
        chk("post_rst_rv", 32'({o_if_rvalid, o_ls_rvalid}), 32'd0);
        tick();

        // Consecutive fetches.
        for (int k = 0; k < 3; k++) begin
            i_if_req = 1; i_if_addr = 32'(4 * k);
            @(negedge clk_sys);
            chk("fetch_gnt", 32'(o_if_gnt), 32'd1);
            chk("fetch_stall", 32'(o_stall_f), 32'd0);
            if (k == 1) chk("fetch_rdata0", o_if_rdata, 32'h1234_5678);
            if (k == 2) chk("fetch_rdata1", o_if_rdata, 32'h1335_5779);
            tick();
        end
        i_if_req = 0;
        @(negedge clk_sys);
        chk("fetch_rdata2", o_if_rdata, 32'h1036_547A);
        tick();

        // Simultaneous fetch and load: load wins.
        i_if_req = 1; i_if_addr = 32'h10; i_ls_req = 1; i_ls_addr = 32'h100;
        @(negedge clk_sys);
        chk("coll_ls_gnt", 32'(o_ls_gnt), 32'd1);
        chk("coll_stall", 32'(o_stall_f), 32'd1);
        tick();
        i_if_req = 0; i_ls_req = 0;
        @(negedge clk_sys);
        chk("coll_ls_rv", 32'(o_ls_rvalid), 32'd1);
        chk("coll_if_rv", 32'(o_if_rvalid), 32'd0);
        chk("coll_ls_rdata", o_ls_rdata, 32'h5274_1638);
        tick();

        // Streak: six loads against a waiting fetch.
        pat_ls = '0; pat_if = '0; ls_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            i_if_req = 1; i_if_addr = 32'h20 + 32'(4 * c);
            i_ls_req = (ls_cnt < 6); i_ls_addr = 32'h300 + 32'(4 * ls_cnt);
            @(negedge clk_sys);
            pat_ls = {pat_ls[5:0], o_ls_gnt};
            pat_if = {pat_if[5:0], o_if_gnt};
            if (o_ls_gnt) ls_cnt++;
            tick();
        end
        chk("streak_ls_pat", 32'(pat_ls), 32'b1111011);
        chk("streak_if_pat", 32'(pat_if), 32'b0000100);
        i_if_req = 0; i_ls_req = 0;
        tick();

        // Partial write then read back.
        i_ls_req = 1; i_ls_we = 1; i_ls_wstrb = 4'b0011; i_ls_wdata = 32'hDEAD_BEEF; i_ls_addr = 32'h200;
        @(negedge clk_sys);
        chk("wr_mem_we", 32'(o_mem_we), 32'b0011);
        tick();
        i_ls_we = 0; i_ls_wstrb = 0;
        @(negedge clk_sys);
        chk("wr_no_rv", 32'(o_ls_rvalid), 32'd0);
        tick();
        i_ls_req = 0;
        @(negedge clk_sys);
        chk("rd_merged", o_ls_rdata, 32'h92B4_BEEF);
        tick();

        // Flush in the response cycle.
        i_if_req = 1; i_if_addr = 32'h40;
        tick();
        i_if_req = 0; i_if_flush = 1;
        @(negedge clk_sys);
        chk("flush_rv", 32'(o_if_rvalid), 32'd0);
        chk("flush_rdata", o_if_rdata, 32'd0);
        tick();
        i_if_flush = 0;

        // Flush alongside a new fetch kills only the older one.
        i_if_req = 1; i_if_addr = 32'h44;
        tick();
        i_if_addr = 32'h48; i_if_flush = 1;
        @(negedge clk_sys);
        chk("flush2_rv", 32'(o_if_rvalid), 32'd0);
        chk("flush2_gnt", 32'(o_if_gnt), 32'd1);
        tick();
        i_if_req = 0; i_if_flush = 0;
        @(negedge clk_sys);
        chk("flush2_new_rdata", o_if_rdata, 32'h0026_446A);
        tick();

        // Reset right after a load grant.
        i_ls_req = 1; i_ls_addr = 32'h100;
        tick();
        i_ls_req = 0; rst_sys = 1;
        @(negedge clk_sys);
        chk("rst_mid_rv", 32'(o_ls_rvalid), 32'd0);
        chk("rst_mid_rdata", o_ls_rdata, 32'd0);
        tick();
        rst_sys = 0;
        @(negedge clk_sys);
        chk("rst_after_rv", 32'(o_ls_rvalid), 32'd0);
        tick();

        // Mixed traffic, checked by the model.
        for (int c = 0; c < 150; c++) begin
            i_if_req   = 1'($urandom_range(0, 1));
            i_if_addr  = 32'h400 + 32'(4 * $urandom_range(0, 15));
            i_if_flush = ($urandom_range(0, 7) == 0);
            i_ls_req   = 1'($urandom_range(0, 1));
            i_ls_we    = 1'($urandom_range(0, 1));
            i_ls_wstrb = 4'($urandom_range(0, 15));
            i_ls_addr  = 32'h400 + 32'(4 * $urandom_range(0, 15));
            i_ls_wdata = $urandom;
            tick();
        end
        i_if_req = 0; i_ls_req = 0; i_if_flush = 0;
        tick();
        tick();
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
